// File: rtl/pcs_tx_pkg.sv
// Shared 10GBASE-R PCS TX definitions: block/word widths, gearbox period and sync headers.
// Imported by the TX gearbox and its window mux.
package pcs_tx_pkg;

  localparam int unsigned BLOCK_W    = 66;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned HDR_W      = 2;
  localparam int unsigned GB_SEQ_MAX = 32;

  localparam logic [HDR_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b10;

  // Packed so that {data, hdr} puts hdr[0] at bit 0, i.e. first on the wire.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [HDR_W-1:0]  hdr;
  } pcs_block_t;

endpackage

// File: rtl/gb_window_select.sv
// Combinational window builder: places a 66-bit block above the 2*fill_sel valid
// residual bits, giving the 128-bit concatenation the gearbox slices from.
module gb_window_select
  import pcs_tx_pkg::*;
(
  input  logic [BLOCK_W-1:0]  blk,
  input  logic [WORD_W-1:0]   res,
  input  logic [4:0]          fill_sel,
  output logic [2*WORD_W-1:0] cat
);

  logic [5:0]          shamt;
  logic [2*WORD_W-1:0] blk_wide;
  logic [2*WORD_W-1:0] res_mask;

  always_comb begin
    shamt    = {fill_sel, 1'b0};
    blk_wide = {{(2*WORD_W-BLOCK_W){1'b0}}, blk} << shamt;
    // Only the low 2*fill_sel residual bits are meaningful; anything above is masked.
    res_mask = ({{(2*WORD_W-1){1'b0}}, 1'b1} << shamt) - {{(2*WORD_W-1){1'b0}}, 1'b1};
    cat      = blk_wide | ({{WORD_W{1'b0}}, res} & res_mask);
  end

endmodule

// File: rtl/tx_gearbox_66_64.sv
// 66b->64b transmit gearbox: 32 blocks in, 33 words out, pausing upstream on the
// 33rd slot to flush the 64-bit residual. Optional bit-reversed output word.
module tx_gearbox_66_64
  import pcs_tx_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [HDR_W-1:0]  hdr_in,
  input  logic [WORD_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic [5:0]        seq_cnt,
  output logic              underflow
);

  localparam logic [5:0] SEQ_PAUSE = 6'(GB_SEQ_MAX);

  pcs_block_t          blk_s;
  logic [BLOCK_W-1:0]  blk;
  logic [2*WORD_W-1:0] cat;
  logic [WORD_W-1:0]   res;
  logic [WORD_W-1:0]   word_q;
  logic                pause;

  always_comb begin
    blk_s.data = data_in;
    blk_s.hdr  = hdr_in;
    blk        = blk_s;
  end

  assign pause    = (seq_cnt == SEQ_PAUSE);
  assign in_ready = !rst && !pause;

  gb_window_select u_win (
    .blk      (blk),
    .res      (res),
    .fill_sel (seq_cnt[4:0]),
    .cat      (cat)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      word_q    <= '0;
      res       <= '0;
      seq_cnt   <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
    end else if (pause) begin
      word_q    <= res;
      res       <= '0;
      seq_cnt   <= '0;
      out_valid <= 1'b1;
      underflow <= 1'b0;
    end else if (in_valid) begin
      word_q    <= cat[WORD_W-1:0];
      res       <= cat[2*WORD_W-1:WORD_W];
      seq_cnt   <= seq_cnt + 6'd1;
      out_valid <= 1'b1;
      underflow <= 1'b0;
    end else begin
      // Starved: hold everything so the stream resumes without a gap in the bit order.
      out_valid <= 1'b0;
      underflow <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(WORD_W); i++) begin
      out_data[i] = REVERSE ? word_q[int'(WORD_W)-1-i] : word_q[i];
    end
  end

endmodule

// File: tb/tb_tx_gearbox_66_64.sv
// Bench for tx_gearbox_66_64: bit-queue reference model of the serial stream,
// driving a normal and a bit-reversed instance with the same stimulus.
module tb_tx_gearbox_66_64;
  import pcs_tx_pkg::*;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  hdr_in = '0;
  logic [63:0] data_in = '0;
  logic        in_valid = 1'b0;

  logic        in_ready, out_valid, underflow;
  logic [63:0] out_data;
  logic [5:0]  seq_cnt;
  logic        in_ready_r, out_valid_r, underflow_r;
  logic [63:0] out_data_r;
  logic [5:0]  seq_cnt_r;

  int total = 0;
  int bad   = 0;

  bit          q[$];
  logic [63:0] exp_data;
  logic        exp_valid, exp_und;
  int          blk_idx;

  always #5 CLK = ~CLK;

  tx_gearbox_66_64 #(.REVERSE(1'b0)) dut (
    .CLK(CLK), .rst(rst), .hdr_in(hdr_in), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .seq_cnt(seq_cnt), .underflow(underflow)
  );

  tx_gearbox_66_64 #(.REVERSE(1'b1)) dut_rev (
    .CLK(CLK), .rst(rst), .hdr_in(hdr_in), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
    .seq_cnt(seq_cnt_r), .underflow(underflow_r)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = w[63-i];
    return r;
  endfunction

  // One cycle, entered and left at a negedge: drive, check in_ready, advance the
  // model, clock, then check the registered outputs of both instances.
  task automatic step(input logic r, input logic v, input logic [1:0] h, input logic [63:0] d);
    logic exp_rdy;
    rst = r; in_valid = v; hdr_in = h; data_in = d;
    #1;
    exp_rdy = !r && (q.size() != 64);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("in_ready_rev", 64'(in_ready_r), 64'(exp_rdy));
    if (r) begin
      q.delete();
      exp_data = '0; exp_valid = 1'b0; exp_und = 1'b0;
    end else if (q.size() == 64 || v) begin
      if (q.size() != 64) begin
        for (int i = 0; i < 2; i++)  q.push_back(h[i]);
        for (int i = 0; i < 64; i++) q.push_back(d[i]);
        blk_idx++;
      end
      for (int i = 0; i < 64; i++) exp_data[i] = q.pop_front();
      exp_valid = 1'b1; exp_und = 1'b0;
    end else begin
      exp_valid = 1'b0; exp_und = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("out_data", out_data, exp_data);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("underflow", 64'(underflow), 64'(exp_und));
    chk("seq_cnt", 64'(seq_cnt), 64'(q.size() / 2));
    chk("out_data_rev", out_data_r, rev64(exp_data));
    chk("seq_cnt_rev", 64'(seq_cnt_r), 64'(q.size() / 2));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'b00, 64'h0);
    step(1'b1, 1'b1, SYNC_DATA, 64'h0);
    blk_idx = 0;
  endtask

  function automatic logic [1:0] rand_hdr();
    return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
  endfunction

  initial begin
    q.delete();
    exp_data = '0; exp_valid = 1'b0; exp_und = 1'b0; blk_idx = 0;
    @(negedge CLK);
    do_reset();
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);

    // First two blocks after reset
    step(1'b0, 1'b1, SYNC_DATA, 64'h0);
    chk("t1_word", out_data, 64'h0000_0000_0000_0001);
    chk("t1_seq", 64'(seq_cnt), 64'd1);
    chk("t1_rev", out_data_r, 64'h8000_0000_0000_0000);
    step(1'b0, 1'b1, SYNC_CTRL, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_word", out_data, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("t2_seq", 64'(seq_cnt), 64'd2);

    // Three full periods with in_valid held high, data = block index
    do_reset();
    for (int c = 0; c < 3 * 33; c++) begin
      logic was_pause;
      was_pause = (q.size() == 64);
      step(1'b0, 1'b1, rand_hdr(), 64'(blk_idx % 32));
      if (was_pause) begin
        chk("pause_word", out_data, 64'h0000_0000_0000_001F);
        chk("pause_seq", 64'(seq_cnt), 64'd0);
      end
      chk("cont_valid", 64'(out_valid), 64'd1);
    end

    // Two-cycle starvation at seq 10
    do_reset();
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, rand_hdr(), {$urandom, $urandom});
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, 2'b00, 64'h0);
      chk("gap_seq", 64'(seq_cnt), 64'd10);
      chk("gap_und", 64'(underflow), 64'd1);
    end
    for (int c = 0; c < 30; c++) step(1'b0, 1'b1, rand_hdr(), {$urandom, $urandom});

    // Reset mid-sequence at seq 20
    do_reset();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, rand_hdr(), {$urandom, $urandom});
    chk("pre_rst_seq", 64'(seq_cnt), 64'd20);
    step(1'b1, 1'b1, rand_hdr(), {$urandom, $urandom});
    chk("mid_rst_data", out_data, 64'h0);
    chk("mid_rst_seq", 64'(seq_cnt), 64'd0);
    blk_idx = 0;
    step(1'b0, 1'b1, SYNC_DATA, 64'h0);
    chk("post_rst_word", out_data, 64'h0000_0000_0000_0001);

    // Random traffic with sporadic starvation and resets
    for (int c = 0; c < 600; c++) begin
      logic r, v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 80);
      step(r, v, rand_hdr(), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_gearbox_66_64.md
Name: tx_gearbox_66_64

Overview:
Transmit gearbox directly downstream of the 64-bit scrambler in the 10GBASE-R PCS TX path. Accepts one 66-bit block per cycle: a 2-bit sync header plus the 64-bit scrambled payload. Emits a continuous 64-bit word stream toward the PMA/SERDES. Every 33rd cycle it back-pressures the upstream block, because 32 blocks × 66 b = 33 words × 64 b.

Parameters:
REVERSE, 0, 0 = out_data[0] is the first transmitted bit (LSB-first); 1 = out_data is bit-reversed so bit 63 is first.

Ports:
CLK  input  1  clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
hdr_in  input  2  sync header; hdr_in[0] transmitted first (2'b01 data, 2'b10 control)
data_in  input  64  scrambled payload; data_in[0] transmitted immediately after hdr_in[1]
in_valid  input  1  hdr_in/data_in valid this cycle
in_ready  output  1  block accepted when in_valid && in_ready
out_data  output  64  gearboxed word
out_valid  output  1  out_data valid
seq_cnt  output  6  current gearbox sequence 0..32 (debug / PMA alignment)
underflow  output  1  one-cycle pulse: in_valid low while in_ready high

Behaviour:
- Block assembly: blk[65:0] = {data_in, hdr_in}. Internal residual register res[63:0] with implicit fill of 2*seq_cnt bits.
- in_ready = !rst && (seq_cnt != 32); combinational from registered seq_cnt.
- seq_cnt in 0..31 with accept (in_valid && in_ready):
  - Form cat = {blk, res[2*seq_cnt-1:0]} (66 + 2*seq_cnt bits, ≤ 128).
  - out_data <= cat[63:0]; res <= cat[127:64] (upper bits beyond fill are don't-care; drive 0).
  - seq_cnt <= seq_cnt+1; out_valid <= 1.
- seq_cnt == 32 (pause slot):
  - No input consumed; res holds exactly 64 bits.
  - out_data <= res; res <= 0; seq_cnt <= 0; out_valid <= 1.
- Underflow: seq_cnt in 0..31 and in_valid low:
  - out_valid <= 0; out_data, res and seq_cnt hold; underflow <= 1 for one cycle.
  - The stream resumes seamlessly on the next accept; no idle block is inserted (that is the encoder's job).
- Latency: exactly 1 cycle from accept to the word carrying that block's first bit.
- REVERSE=1: registered word bit-reversed at output only; internal ordering unchanged.
- Reset: out_data=0, out_valid=0, seq_cnt=0, res=0, underflow=0, in_ready=0 while rst high. rst overrides everything including mid-sequence and the pause slot. Any partially shifted residual is discarded. First accept after release is treated as seq 0.
- Simultaneous in_valid with seq_cnt==32: input ignored (in_ready low). Upstream must hold the block, and the scrambler must not advance on that cycle.
- Throughput: with in_valid tied high, out_valid is continuously 1 and exactly 32 accepts occur per 33 cycles.

Decomposition:
- Package pcs_tx_pkg: localparams BLOCK_W=66, WORD_W=64, HDR_W=2, GB_SEQ_MAX=32; typedef pcs_block_t (struct {logic [63:0] data; logic [1:0] hdr;}); sync header constants SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
- Single module; the variable-offset concat/select (seq_cnt-indexed 128-bit window) may be factored into sub-module gb_window_select (purely combinational mux) for reuse by the RX gearbox.

Test Plan:
1. Reset, then block0 hdr=2'b01 data=64'h0 -> next cycle out_data=64'h0000_0000_0000_0001, out_valid=1, seq_cnt=1.
2. Follow with block1 hdr=2'b10 data=64'hFFFF_FFFF_FFFF_FFFF -> out_data=64'hFFFF_FFFF_FFFF_FFF8, seq_cnt=2.
3. in_valid held high, 32 blocks with data=block index -> in_ready low exactly on cycle 33. Pause-slot out_data=64'h0000_0000_0000_001F (data of block 31). seq_cnt returns 0 and the pattern repeats identically over 3 periods. Reference-model bit-stream compare matches.
4. Drop in_valid for 2 cycles at seq_cnt=10 -> out_valid=0 and underflow=1 both cycles, seq_cnt stays 10. Resumed output bit-stream is identical to the no-gap case.
5. Assert rst at seq_cnt=20 for 1 cycle -> all outputs 0 during reset. Next accept of hdr=2'b01 data=0 yields 64'h…0001 at seq 0.
6. REVERSE=1 rerun of scenario 1 -> out_data=64'h8000_0000_0000_0000.
